ask_mod_pipe: RTL and testbench

Clocked, pipelined multi-level ASK modulator. It multiplies a streaming signed carrier sample by a signed baseband symbol. Each symbol is held for a programmable number of carrier samples.
Sits between the carrier NCO/LUT and the DAC formatter. Symbols arrive through a valid/ready handshake with a one-deep look-ahead buffer, so consecutive symbols apply back-to-back with no gap.

---
 rtl/ask_mod_pipe.sv | 169 ++++++++++++++++
 tb/tb_ask_mod_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ask_mod_pipe.sv
// ask_mod_pipe: 3-stage pipelined multi-level ASK modulator (carrier x held baseband symbol).
// Optional macro ASK_UNDERRUN_CNT_EN adds a saturating 16-bit underrun pulse counter port.
module ask_mod_pipe #(
    parameter int CW_W    = 10,
    parameter int BS_W    = 3,
    parameter int SYM_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [CW_W-1:0]        car_data,
    input  logic                          car_valid,
    input  logic signed [BS_W-1:0]        sym_data,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    output logic signed [CW_W+BS_W-1:0]   mod_data,
    output logic                          mod_valid,
    output logic                          busy,
    output logic                          underrun
`ifdef ASK_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt
`endif
);

    // state | meaning
    // IDLE  | no symbol active, carrier samples are multiplied by 0
    // RUN   | current symbol applied, counting carrier samples to the boundary

    localparam int PW = CW_W + BS_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_nx;
    logic signed [BS_W-1:0] cur_sym, cur_sym_nx;
    logic signed [BS_W-1:0] nxt_sym, nxt_sym_nx;
    logic                   nxt_full, nxt_full_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   underrun_nx;
    logic                   boundary;
    logic                   xfer;

    assign boundary  = (state == RUN) && car_valid && (cnt == CNT_W'(SYM_LEN - 1));
    assign sym_ready = !nxt_full || boundary;
    assign xfer      = sym_valid && sym_ready;
    assign busy      = (state == RUN);

    always_comb begin
        state_nx    = state;
        cur_sym_nx  = cur_sym;
        nxt_sym_nx  = nxt_sym;
        nxt_full_nx = nxt_full;
        cnt_nx      = cnt;
        underrun_nx = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    cur_sym_nx = sym_data;
                    cnt_nx     = '0;
                    state_nx   = RUN;
                end
            end
            RUN: begin
                if (car_valid) cnt_nx = cnt + CNT_W'(1);
                if (boundary) begin
                    cnt_nx = '0;
                    if (nxt_full) begin
                        cur_sym_nx  = nxt_sym;
                        nxt_full_nx = xfer;
                        if (xfer) nxt_sym_nx = sym_data;
                    end else if (xfer) begin
                        // late arrival on the boundary still counts as buffered in time
                        cur_sym_nx = sym_data;
                    end else begin
                        cur_sym_nx  = '0;
                        state_nx    = IDLE;
                        underrun_nx = 1'b1;
                    end
                end else if (xfer) begin
                    nxt_sym_nx  = sym_data;
                    nxt_full_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_sym  <= '0;
            nxt_sym  <= '0;
            nxt_full <= 1'b0;
            cnt      <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_sym  <= cur_sym_nx;
            nxt_sym  <= nxt_sym_nx;
            nxt_full <= nxt_full_nx;
            cnt      <= cnt_nx;
            underrun <= underrun_nx;
        end
    end

`ifdef ASK_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun_nx && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

    // Magnitudes carry one extra bit so the most negative inputs are exact.
    logic [CW_W:0] car_ext, car_mag;
    logic [BS_W:0] sym_ext, sym_mag;

    assign car_ext = {car_data[CW_W-1], car_data};
    assign car_mag = car_ext[CW_W] ? (~car_ext + (CW_W+1)'(1)) : car_ext;
    assign sym_ext = {cur_sym[BS_W-1], cur_sym};
    assign sym_mag = sym_ext[BS_W] ? (~sym_ext + (BS_W+1)'(1)) : sym_ext;

    logic          s1_valid, s1_sign;
    logic [CW_W:0] s1_mag_a;
    logic [BS_W:0] s1_mag_b;
    logic          s2_valid, s2_sign;
    logic [PW-1:0] s2_mag;
    logic [PW-1:0] prod_mag;

    always_comb begin
        prod_mag = '0;
        for (int i = 0; i <= BS_W; i++) begin
            if (s1_mag_b[i]) prod_mag = prod_mag + (PW'(s1_mag_a) << i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_mag_a  <= '0;
            s1_mag_b  <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= '0;
            mod_valid <= 1'b0;
            mod_data  <= '0;
        end else begin
            s1_valid <= car_valid;
            if (car_valid) begin
                s1_sign  <= car_data[CW_W-1] ^ cur_sym[BS_W-1];
                s1_mag_a <= car_mag;
                s1_mag_b <= sym_mag;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_mag  <= prod_mag;
            end
            mod_valid <= s2_valid;
            if (s2_valid) begin
                mod_data <= s2_sign ? (~s2_mag + PW'(1)) : s2_mag;
            end
        end
    end

endmodule

// File: tb/tb_ask_mod_pipe.sv
// Self-checking bench for ask_mod_pipe: randomized and directed stimulus against a
// symbol-queue reference model with a plain-multiply 3-cycle delay line.
module tb_ask_mod_pipe;

    localparam int CW_W    = 10;
    localparam int BS_W    = 3;
    localparam int SYM_LEN = 4;
    localparam int CNT_W   = 8;
    localparam int PW      = CW_W + BS_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [CW_W-1:0] car_data;
    logic                 car_valid;
    logic signed [BS_W-1:0] sym_data;
    logic                 sym_valid;
    logic                 sym_ready;
    logic signed [PW-1:0] mod_data;
    logic                 mod_valid;
    logic                 busy;
    logic                 underrun;
`ifdef ASK_UNDERRUN_CNT_EN
    logic [15:0]          underrun_cnt;
`endif

    ask_mod_pipe #(.CW_W(CW_W), .BS_W(BS_W), .SYM_LEN(SYM_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .car_data  (car_data),
        .car_valid (car_valid),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .mod_data  (mod_data),
        .mod_valid (mod_valid),
        .busy      (busy),
        .underrun  (underrun)
`ifdef ASK_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: active symbol with samples remaining, plus pending symbols
    bit m_active;
    int m_cur;
    int m_left;
    int pend[$];
    bit p_v[3];
    int p_d[3];
    bit e_mv, e_under, e_ready;
    int e_md;
    int m_ucnt;
    bit obs_ready;
    int obs_q[$];
    int n_pulse;

    task automatic m_clear();
        m_active = 0; m_cur = 0; m_left = 0; pend.delete();
        for (int i = 0; i < 3; i++) begin p_v[i] = 0; p_d[i] = 0; end
        e_mv = 0; e_md = 0; e_under = 0; m_ucnt = 0;
    endtask

    task automatic step(input bit cv, input int cd, input bit sv, input int sd);
        bit xfer, done;
        int tag;
        car_valid = cv; car_data = 10'(cd); sym_valid = sv; sym_data = 3'(sd);
        e_ready = (pend.size() == 0) || (m_active && cv && m_left == 1);
        #1 obs_ready = sym_ready;
        @(posedge clk);
        xfer = sv && e_ready;
        done = 0;
        tag = m_active ? m_cur : 0;
        e_under = 0;
        p_v[2] = p_v[1]; p_d[2] = p_d[1];
        p_v[1] = p_v[0]; p_d[1] = p_d[0];
        p_v[0] = cv;     p_d[0] = cd * tag;
        if (!m_active) begin
            if (xfer) begin m_active = 1; m_cur = sd; m_left = SYM_LEN; done = 1; end
        end else begin
            if (cv) begin
                m_left--;
                if (m_left == 0) begin
                    m_left = SYM_LEN;
                    if (pend.size() > 0) m_cur = pend.pop_front();
                    else if (xfer) begin m_cur = sd; done = 1; end
                    else begin m_active = 0; m_cur = 0; e_under = 1; m_ucnt++; end
                end
            end
            if (xfer && !done) pend.push_back(sd);
        end
        e_mv = p_v[2];
        if (p_v[2]) e_md = p_d[2];
        #1;
        if (mod_valid) obs_q.push_back(int'(mod_data));
        if (underrun) n_pulse++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_active; i++) step(1, 0, 0, 0);
        n_vec++;
        if (m_active) begin
            n_err++;
            $display("FAIL drain_timeout: busy=%0b required 0", busy);
        end
        repeat (3) step(0, 0, 0, 0);
        obs_q.delete();
        n_pulse = 0;
    endtask

    task automatic test_reset();
        repeat (5) step(1, 50, 1, 1);
        rst_n = 0;
        #1;
        n_vec += 5;
        if (mod_data !== '0)    begin n_err++; $display("FAIL rst_mod_data: got %0d want 0", mod_data); end
        if (mod_valid !== 1'b0) begin n_err++; $display("FAIL rst_mod_valid: got %b want 0", mod_valid); end
        if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (underrun !== 1'b0)  begin n_err++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        if (sym_ready !== 1'b1) begin n_err++; $display("FAIL rst_sym_ready: got %b want 1", sym_ready); end
        m_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            step(k == 2, 20, 0, 0);
            n_vec++;
            if (mod_valid !== (k == 4)) begin
                n_err++; $display("FAIL rst_release_valid[%0d]: got %b want %b", k, mod_valid, (k == 4));
            end
        end
        n_vec++;
        if (mod_data !== '0) begin n_err++; $display("FAIL rst_release_data: got %0d want 0", mod_data); end
    endtask

    task automatic test_basic();
        drain();
        step(0, 0, 1, 3);
        for (int i = 0; i < 16; i++) begin
            step(1, (i < 8) ? 100 : -200, 1, 3);
            n_vec++;
            if (mod_valid !== e_mv || mod_data !== PW'(e_md)) begin
                n_err++; $display("FAIL basic_step[%0d]: got v=%b d=%0d want v=%b d=%0d", i, mod_valid, mod_data, e_mv, e_md);
            end
        end
        repeat (3) step(0, 0, 0, 0);
        n_vec++;
        if (obs_q.size() != 16) begin
            n_err++; $display("FAIL basic_count: got %0d want 16", obs_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_vec++;
                if (obs_q[i] != ((i < 8) ? 300 : -600)) begin
                    n_err++; $display("FAIL basic_value[%0d]: got %0d want %0d", i, obs_q[i], (i < 8) ? 300 : -600);
                end
            end
        end
    endtask

    task automatic test_extremes();
        int want[5];
        want[0] = 2048; want[1] = -2044; want[2] = 0; want[3] = 0; want[4] = 0;
        drain();
        step(0, 0, 1, -4);
        step(1, -512, 0, 0);
        step(1, 511, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 300, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        n_vec++;
        if (obs_q.size() != 5) begin
            n_err++; $display("FAIL ext_count: got %0d want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (obs_q[i] != want[i]) begin
                    n_err++; $display("FAIL ext_value[%0d]: got %0d want %0d", i, obs_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        drain();
        step(0, 0, 1, 1);
        step(0, 0, 1, -2);
        step(0, 0, 1, 3);
        n_vec++;
        if (obs_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b want 0", obs_ready); end
        for (int i = 0; i < 8; i++) begin
            step(1, 10, 0, 0);
            if (i == 6) begin
                n_vec++;
                if (n_pulse != 0) begin n_err++; $display("FAIL b2b_no_underrun: got %0d want 0", n_pulse); end
            end
        end
        repeat (3) step(0, 0, 0, 0);
        n_vec++;
        if (obs_q.size() != 8) begin
            n_err++; $display("FAIL b2b_count: got %0d want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (obs_q[i] != ((i < 4) ? 10 : -20)) begin
                    n_err++; $display("FAIL b2b_value[%0d]: got %0d want %0d", i, obs_q[i], (i < 4) ? 10 : -20);
                end
            end
        end
    endtask

    task automatic test_underrun();
`ifdef ASK_UNDERRUN_CNT_EN
        logic [15:0] base;
`endif
        drain();
`ifdef ASK_UNDERRUN_CNT_EN
        base = underrun_cnt;
`endif
        step(0, 0, 1, 2);
        for (int i = 0; i < 6; i++) begin
            step(1, 5, 0, 0);
            if (i == 3) begin
                n_vec++;
                if (underrun !== 1'b1 || busy !== 1'b0) begin
                    n_err++; $display("FAIL und_boundary: got underrun=%b busy=%b want 1 0", underrun, busy);
                end
            end
        end
        repeat (3) step(0, 0, 0, 0);
        n_vec++;
        if (n_pulse != 1) begin n_err++; $display("FAIL und_pulses: got %0d want 1", n_pulse); end
        n_vec++;
        if (obs_q.size() != 6) begin
            n_err++; $display("FAIL und_count: got %0d want 6", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (obs_q[i] != ((i < 4) ? 10 : 0)) begin
                    n_err++; $display("FAIL und_value[%0d]: got %0d want %0d", i, obs_q[i], (i < 4) ? 10 : 0);
                end
            end
        end
`ifdef ASK_UNDERRUN_CNT_EN
        n_vec++;
        if (underrun_cnt - base !== 16'd1) begin
            n_err++; $display("FAIL und_cnt_delta: got %0d want 1", underrun_cnt - base);
        end
        n_vec++;
        if (underrun_cnt !== 16'(m_ucnt)) begin
            n_err++; $display("FAIL und_cnt_total: got %0d want %0d", underrun_cnt, m_ucnt);
        end
`endif
    endtask

    task automatic test_gapped();
        drain();
        step(0, 0, 1, 1);
        step(0, 0, 1, 2);
        for (int i = 0; i < 16; i++) begin
            step((i % 2) == 0, 7, 0, 0);
            n_vec++;
            if (mod_valid !== e_mv) begin
                n_err++; $display("FAIL gap_valid[%0d]: got %b want %b", i, mod_valid, e_mv);
            end
        end
        repeat (3) step(0, 0, 0, 0);
        n_vec++;
        if (obs_q.size() != 8) begin
            n_err++; $display("FAIL gap_count: got %0d want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (obs_q[i] != ((i < 4) ? 7 : 14)) begin
                    n_err++; $display("FAIL gap_value[%0d]: got %0d want %0d", i, obs_q[i], (i < 4) ? 7 : 14);
                end
            end
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 1023)) - 512,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 7)) - 4);
            n_vec++;
            if (obs_ready !== e_ready || mod_valid !== e_mv || mod_data !== PW'(e_md) ||
                busy !== m_active || underrun !== e_under) begin
                n_err++;
                $display("FAIL rnd[%0d]: got rdy=%b v=%b d=%0d busy=%b und=%b want rdy=%b v=%b d=%0d busy=%b und=%b",
                         i, obs_ready, mod_valid, mod_data, busy, underrun,
                         e_ready, e_mv, e_md, m_active, e_under);
            end
        end
    endtask

    initial begin
        rst_n = 0; car_valid = 0; car_data = '0; sym_valid = 0; sym_data = '0;
        n_pulse = 0;
        m_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_underrun();
        test_gapped();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
